// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM state encoding,
// well-known command/response bytes, default timing constants (50 MHz core),
// counter widths and the frame/parity helpers used to load the shift register.
package ps2_pkg;

  // Transmit FSM states. DONE and ERR are single-cycle pulse states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_REQ      = 3'd2,
    ST_SEND     = 3'd3,
    ST_ACK      = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6,
    ST_WAIT_IDL = 3'd7
  } ps2_tx_state_t;

  // Common keyboard command and response bytes.
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // Default timing at a 50 MHz core clock.
  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;    // 100 us clock inhibit
  localparam int unsigned DEF_START_TIMEOUT  = 750000;  // 15 ms for device to start clocking
  localparam int unsigned DEF_XFER_TIMEOUT   = 100000;  // 2 ms from first edge to ACK

  // Counter widths; both counters saturate instead of wrapping.
  localparam int TIMER_W  = 20;
  localparam int BITCNT_W = 4;

  // Frame bits 0..10: start(0), data[0..7], parity, stop(1).
  localparam int FRAME_W = 11;

  // Value of the bit counter on the falling edge that puts the stop bit out.
  // fe1 enters SEND with the counter cleared, so fe10 sees a count of 8.
  localparam logic [BITCNT_W-1:0] BITCNT_STOP = 4'd8;

  // Idle level of both open-drain lines (pulled up).
  localparam logic LINE_IDLE = 1'b1;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Full frame as it leaves the wire, LSB first.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] d);
    return {1'b1, odd_parity(d), d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 2-FF synchroniser for one PS/2 line plus a falling-edge detector.
// Latency: o_sync lags i_line by 2 clocks; o_fell pulses 1 cycle when o_sync goes 1 -> 0.
// No backpressure: free-running sampler.
// Ports:
//   i_clk    in   core clock
//   i_rst_n  in   async active-low reset; flops reset to the idle (high) line level
//   i_line   in   raw, asynchronous line value
//   o_sync   out  synchronised line level
//   o_fell   out  1-cycle pulse on a synchronised falling edge
module ps2_sync_edge
  import ps2_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_sync,
  output logic o_fell
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Resetting to the idle level keeps a line that is already high from
  // producing a spurious edge when reset is released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= LINE_IDLE;
      r_sync <= LINE_IDLE;
      r_prev <= LINE_IDLE;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fell = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame, device ACK check.
// Latency: INHIBIT_CYCLES of clock inhibit, then paced by the device clock; done/error 1 cycle after fe11.
// Backpressure: tx_start is accepted only while tx_busy is low; requests while busy are dropped.
// Ports:
//   inclock    in     core clock (50 MHz nominal)
//   resetn     in     async active-low reset; releases both lines immediately
//   ps2_clock  inout  open-drain PS/2 clock (driven 0 or released)
//   ps2_data   inout  open-drain PS/2 data  (driven 0 or released)
//   tx_data    in     command byte, captured on accept
//   tx_start   in     transmit request
//   tx_busy    out    high from the cycle after accept until back in IDLE
//   tx_done    out    1-cycle pulse, device acknowledged
//   tx_error   out    1-cycle pulse, timeout or missing ACK
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int unsigned XFER_TIMEOUT   = DEF_XFER_TIMEOUT
) (
  input  logic       inclock,
  input  logic       resetn,
  inout  wire        ps2_clock,
  inout  wire        ps2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  // Terminal counts: the timer starts at 0 on state entry, so a phase of
  // N cycles ends when the timer reads N-1.
  localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST  = TIMER_W'(XFER_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
  localparam logic [BITCNT_W-1:0] BITCNT_MAX = '1;

  ps2_tx_state_t        r_state;
  ps2_tx_state_t        w_state_nxt;
  logic [TIMER_W-1:0]   r_timer;
  logic [BITCNT_W-1:0]  r_bit_cnt;
  logic [FRAME_W-1:0]   r_shift;

  logic w_clk_sync;
  logic w_clk_fell;
  logic w_dat_sync;
  logic w_unused_dat_fell;

  logic w_load;
  logic w_shift;
  logic w_timer_clr;
  logic w_timing;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_clk_lo;
  logic w_dat_lo;

  // ---------------------------------------------------------------------------
  // Line sampling
  // ---------------------------------------------------------------------------
  ps2_sync_edge u_sync_clk (
    .i_clk   (inclock),
    .i_rst_n (resetn),
    .i_line  (ps2_clock),
    .o_sync  (w_clk_sync),
    .o_fell  (w_clk_fell)
  );

  // Only the level of the data line matters; its edge output is not needed.
  ps2_sync_edge u_sync_dat (
    .i_clk   (inclock),
    .i_rst_n (resetn),
    .i_line  (ps2_data),
    .o_sync  (w_dat_sync),
    .o_fell  (w_unused_dat_fell)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_timer_clr = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_state_nxt = ST_INHIBIT;
          w_load      = 1'b1;
          w_timer_clr = 1'b1;
        end
      end

      ST_INHIBIT: begin
        if (r_timer == INH_LAST) begin
          w_state_nxt = ST_REQ;
          w_timer_clr = 1'b1;
        end
      end

      // fe1 both starts the frame and shifts out data[0]; the transfer
      // timer is restarted here so it measures fe1 -> fe11.
      ST_REQ: begin
        if (w_clk_fell) begin
          w_state_nxt = ST_SEND;
          w_shift     = 1'b1;
          w_cnt_clr   = 1'b1;
          w_timer_clr = 1'b1;
        end else if (r_timer == START_LAST) begin
          w_state_nxt = ST_ERR;
        end
      end

      ST_SEND: begin
        if (r_timer == XFER_LAST) begin
          w_state_nxt = ST_ERR;
        end else if (w_clk_fell) begin
          w_shift   = 1'b1;
          w_cnt_inc = 1'b1;
          if (r_bit_cnt == BITCNT_STOP) begin
            w_state_nxt = ST_ACK;
          end
        end
      end

      // Synced data and synced clock share the same delay, so the data level
      // seen alongside the clock edge is the one the device presented.
      ST_ACK: begin
        if (r_timer == XFER_LAST) begin
          w_state_nxt = ST_ERR;
        end else if (w_clk_fell) begin
          w_state_nxt = w_dat_sync ? ST_ERR : ST_DONE;
        end
      end

      ST_DONE,
      ST_ERR: begin
        w_state_nxt = ST_WAIT_IDL;
      end

      ST_WAIT_IDL: begin
        if (w_clk_sync && w_dat_sync) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared timer (inhibit length, start timeout, transfer timeout)
  // ---------------------------------------------------------------------------
  assign w_timing = (r_state == ST_INHIBIT) || (r_state == ST_REQ) ||
                    (r_state == ST_SEND)    || (r_state == ST_ACK);

  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      r_timer <= '0;
    end else if (w_timer_clr) begin
      r_timer <= '0;
    end else if (w_timing && (r_timer != TIMER_MAX)) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit counter and frame shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      r_bit_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_bit_cnt <= '0;
    end else if (w_cnt_inc && (r_bit_cnt != BITCNT_MAX)) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Bit 0 is always the bit on the wire. Shifting in ones means that once the
  // stop bit has gone out the data line stays released.
  always_ff @(posedge inclock or negedge resetn) begin
    if (!resetn) begin
      r_shift <= '1;
    end else if (w_load) begin
      r_shift <= build_frame(tx_data);
    end else if (w_shift) begin
      r_shift <= {1'b1, r_shift[FRAME_W-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Open-drain drivers
  // ---------------------------------------------------------------------------
  // Drive enables decode registered state only, so an async reset or entry to
  // ERR releases both lines straight away. The start bit goes out in the last
  // inhibit cycle so data is already low when the clock is released.
  assign w_clk_lo = (r_state == ST_INHIBIT);
  assign w_dat_lo = ((r_state == ST_INHIBIT) && (r_timer == INH_LAST)) ||
                    (((r_state == ST_REQ) || (r_state == ST_SEND)) && !r_shift[0]);

  assign ps2_clock = w_clk_lo ? 1'b0 : 1'bz;
  assign ps2_data  = w_dat_lo ? 1'b0 : 1'bz;

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  assign tx_busy  = (r_state != ST_IDLE);
  assign tx_done  = (r_state == ST_DONE);
  assign tx_error = (r_state == ST_ERR);

endmodule
